// File: rtl/id_ex_pkg.sv
// Shared types and constants for the ID/EX stage: ALU opcodes, datapath widths,
// and the EX register payload with its bubble value.
package id_ex_pkg;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned REG_W   = 5;
    localparam int unsigned OP_W    = 4;
    localparam int unsigned SHAMT_W = 5;

    localparam logic [OP_W-1:0] ALU_ADD  = 4'b0000;
    localparam logic [OP_W-1:0] ALU_ADDU = 4'b0001;
    localparam logic [OP_W-1:0] ALU_SUB  = 4'b0010;
    localparam logic [OP_W-1:0] ALU_SUBU = 4'b0011;
    localparam logic [OP_W-1:0] ALU_SLT  = 4'b0100;
    localparam logic [OP_W-1:0] ALU_SLTU = 4'b0101;
    localparam logic [OP_W-1:0] ALU_AND  = 4'b0110;
    localparam logic [OP_W-1:0] ALU_LUI  = 4'b0111;
    localparam logic [OP_W-1:0] ALU_NOR  = 4'b1000;
    localparam logic [OP_W-1:0] ALU_OR   = 4'b1001;
    localparam logic [OP_W-1:0] ALU_XOR  = 4'b1010;
    localparam logic [OP_W-1:0] ALU_SLL  = 4'b1011;
    localparam logic [OP_W-1:0] ALU_SRA  = 4'b1100;
    localparam logic [OP_W-1:0] ALU_SRL  = 4'b1101;

    // ADDU on zeros never traps, so bubbles are safe to feed the ALU
    localparam logic [OP_W-1:0]  BUBBLE_OP = ALU_ADDU;
    localparam logic [REG_W-1:0] REG_ZERO  = '0;

    typedef struct packed {
        logic              valid;
        logic [OP_W-1:0]   alu_op;
        logic [DATA_W-1:0] din1;
        logic [DATA_W-1:0] din2;
        logic [REG_W-1:0]  dest;
        logic              reg_write;
        logic              mem_read;
        logic              mem_write;
        logic [DATA_W-1:0] store_data;
    } ex_reg_t;

    function automatic ex_reg_t ex_bubble();
        ex_reg_t b;
        b        = '0;
        b.alu_op = BUBBLE_OP;
        return b;
    endfunction

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// Per-operand forward select: EX result beats MEM result beats register file.
// Also reports whether any in-flight producer targets this operand.
module fwd_mux
    import id_ex_pkg::*;
(
    input  logic [REG_W-1:0]  src_idx_i,
    input  logic [DATA_W-1:0] rf_data_i,
    input  logic              ex_write_i,
    input  logic [REG_W-1:0]  ex_idx_i,
    input  logic [DATA_W-1:0] ex_data_i,
    input  logic              mem_write_i,
    input  logic [REG_W-1:0]  mem_idx_i,
    input  logic [DATA_W-1:0] mem_data_i,
    output logic [DATA_W-1:0] fwd_data_c,
    output logic              raw_hit_c
);

    logic ex_hit;
    logic mem_hit;

    // $zero is hardwired, so it never takes a forwarded value
    assign ex_hit  = ex_write_i  && (ex_idx_i  == src_idx_i) && (src_idx_i != REG_ZERO);
    assign mem_hit = mem_write_i && (mem_idx_i == src_idx_i) && (src_idx_i != REG_ZERO);

    always_comb begin
        fwd_data_c = rf_data_i;
        if (ex_hit) begin
            fwd_data_c = ex_data_i;
        end else if (mem_hit) begin
            fwd_data_c = mem_data_i;
        end
    end

    assign raw_hit_c = ex_hit | mem_hit;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding, load-use bubbles, stall and flush.
// ID_EX_FWD_EN selects forwarding; without it any RAW on EX/MEM stalls ID instead.
module id_ex_stage
    import id_ex_pkg::*;
(
    input  logic              clk,
    input  logic              rstn,
    input  logic              idValid,
    input  logic [OP_W-1:0]   idAluOp,
    input  logic [REG_W-1:0]  idRsIdx,
    input  logic [REG_W-1:0]  idRtIdx,
    input  logic [REG_W-1:0]  idDest,
    input  logic [DATA_W-1:0] idRsData,
    input  logic [DATA_W-1:0] idRtData,
    input  logic [DATA_W-1:0] idImm,
    input  logic [4:0]        idShamt,
    input  logic              idUseImm,
    input  logic              idUseShamt,
    input  logic              idRegWrite,
    input  logic              idMemRead,
    input  logic              idMemWrite,
    input  logic              exStall,
    input  logic              flush,
    input  logic              exFwdWrite,
    input  logic              memFwdWrite,
    input  logic [REG_W-1:0]  exFwdIdx,
    input  logic [REG_W-1:0]  memFwdIdx,
    input  logic [DATA_W-1:0] exFwdData,
    input  logic [DATA_W-1:0] memFwdData,
    output logic              idStall,
    output logic              exValid,
    output logic [OP_W-1:0]   aluOp,
    output logic [DATA_W-1:0] din1,
    output logic [DATA_W-1:0] din2,
    output logic [REG_W-1:0]  exDest,
    output logic              exRegWrite,
    output logic              exMemRead,
    output logic              exMemWrite,
    output logic [DATA_W-1:0] exStoreData
);

    ex_reg_t           ex_q;
    ex_reg_t           ex_d;
    logic [DATA_W-1:0] fwd_rs;
    logic [DATA_W-1:0] fwd_rt;
    logic              rs_raw;
    logic              rt_raw;
    logic              rs_used;
    logic              load_use;
    logic              hazard;
    logic [DATA_W-1:0] rs_val;
    logic [DATA_W-1:0] rt_val;

    fwd_mux u_fwd_rs (
        .src_idx_i   (idRsIdx),
        .rf_data_i   (idRsData),
        .ex_write_i  (exFwdWrite),
        .ex_idx_i    (exFwdIdx),
        .ex_data_i   (exFwdData),
        .mem_write_i (memFwdWrite),
        .mem_idx_i   (memFwdIdx),
        .mem_data_i  (memFwdData),
        .fwd_data_c  (fwd_rs),
        .raw_hit_c   (rs_raw)
    );

    fwd_mux u_fwd_rt (
        .src_idx_i   (idRtIdx),
        .rf_data_i   (idRtData),
        .ex_write_i  (exFwdWrite),
        .ex_idx_i    (exFwdIdx),
        .ex_data_i   (exFwdData),
        .mem_write_i (memFwdWrite),
        .mem_idx_i   (memFwdIdx),
        .mem_data_i  (memFwdData),
        .fwd_data_c  (fwd_rt),
        .raw_hit_c   (rt_raw)
    );

    // Shifts take their first operand from shamt, so rs is not a real dependency
    assign rs_used  = !idUseShamt;
    assign load_use = ex_q.valid && ex_q.mem_read && (ex_q.dest != REG_ZERO) &&
                      ((rs_used && (ex_q.dest == idRsIdx)) || (ex_q.dest == idRtIdx));

`ifdef ID_EX_FWD_EN
    logic unused_raw;
    assign unused_raw = rs_raw | rt_raw;
    assign rs_val     = fwd_rs;
    assign rt_val     = fwd_rt;
    assign hazard     = load_use;
`else
    logic unused_fwd;
    assign unused_fwd = ^{fwd_rs, fwd_rt};
    assign rs_val     = idRsData;
    assign rt_val     = idRtData;
    assign hazard     = load_use || (rs_used && rs_raw) || rt_raw;
`endif

    // Priority: flush, downstream stall, hazard bubble, capture, idle bubble
    always_comb begin
        ex_d    = ex_bubble();
        idStall = 1'b0;
        if (flush) begin
            ex_d = ex_bubble();
        end else if (exStall) begin
            ex_d    = ex_q;
            idStall = 1'b1;
        end else if (hazard) begin
            idStall = 1'b1;
        end else if (idValid) begin
            ex_d.valid      = 1'b1;
            ex_d.alu_op     = idAluOp;
            ex_d.din1       = idUseShamt ? DATA_W'(idShamt) : rs_val;
            ex_d.din2       = idUseImm ? idImm : rt_val;
            ex_d.dest       = idDest;
            ex_d.reg_write  = idRegWrite;
            ex_d.mem_read   = idMemRead;
            ex_d.mem_write  = idMemWrite;
            ex_d.store_data = rt_val;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            ex_q <= ex_bubble();
        end else begin
            ex_q <= ex_d;
        end
    end

    assign exValid     = ex_q.valid;
    assign aluOp       = ex_q.alu_op;
    assign din1        = ex_q.din1;
    assign din2        = ex_q.din2;
    assign exDest      = ex_q.dest;
    assign exRegWrite  = ex_q.reg_write;
    assign exMemRead   = ex_q.mem_read;
    assign exMemWrite  = ex_q.mem_write;
    assign exStoreData = ex_q.store_data;

endmodule
